eusci_rx_baudgen: RTL
=====================

# eusci_rx_baudgen

UART receive baud-rate generator for the eUSCI_A block; sits directly upstream of the receive state machine. It synchronizes the raw Rx pin and detects the start-bit falling edge. It then generates the BITCLK whose rising edge lands at mid-bit, which the receive state machine samples on. It supports low-frequency (UCOS16=0) and 16x oversampling (UCOS16=1) modes with UCBRF/UCBRS modulation.

## Interface
- No parameters; all divisor settings are run-time register fields.
- MCLK  in  1  system clock; only clock
- reset_n  in  1  reset, synchronous, active-low
- BRCLKEN  in  1  BRCLK qualifier; counters advance only on MCLK cycles with BRCLKEN=1
- wUCSWRST  in  1  software reset; 1 forces IDLE, same effect as reset except RxSync
- wUCOS16  in  1  oversampling mode select
- wUCBRW  in  16  prescaler; 0 is treated as 1
- wUCBRF  in  4  first-stage modulation (OS16 only)
- wUCBRS  in  8  second-stage modulation pattern, indexed by bit number
- Rx  in  1  asynchronous UART pin
- RxBusy  in  1  from receive state machine; high while a frame is in progress
- BITCLK  out  1  bit clock to receive state machine; rising edge = mid-bit
- RxSync  out  1  synchronized (optionally deglitched) Rx fed to receive state machine
- Running  out  1  high in states START/RUN

## Operation
- RxSync: 2-FF synchronizer, reset value 1. Start detect = RxSync 1→0 while in IDLE and wUCSWRST=0.
- States: IDLE → START on start detect. START → RUN on the 2nd BITCLK rising edge if RxBusy=1; otherwise → IDLE (false start). RUN → IDLE on the first cycle RxBusy=0. Any state → IDLE on wUCSWRST=1 or reset.
- Bit period N, in enabled cycles, for bit index b (0..7, wraps; b=0 is the start bit): UCBRS[b] adds one BRCLK to the bit.
  - UCOS16=0: N = UCBRW + UCBRS[b].
  - UCOS16=1: each bit is 16 sub-ticks. Sub-tick i (0..15) lasts UCBRW+1 if i < UCBRF, else UCBRW. The UCBRS extra BRCLK is added to sub-tick 15.
- BITCLK is 0 in the first half of each bit and 1 in the second half.
  - UCOS16=0: rises when the in-bit count reaches floor(N/2).
  - UCOS16=1: rises at the start of sub-tick 8.
  - Falls at the bit boundary.
- Counters: 16-bit prescale count, 4-bit sub-tick count, 3-bit bit index. All clear on entering START.

## Timing
- Reset values: BITCLK=0, RxSync=1, Running=0, state IDLE, all counters 0.
- Rx→RxSync latency is 2 MCLK, or 2+3 MCLK when the deglitch feature is compiled in.
- Start detect registers START on the next MCLK edge. Bit 0 count begins that cycle.
- BITCLK is registered. With BRCLKEN=1 continuously, in UCOS16=0, the first rising edge occurs floor(N/2)+1 MCLK after START entry. Subsequent rising edges are spaced N MCLK apart.
- BRCLKEN=0 freezes all counters and holds BITCLK.
- IDLE forces BITCLK=0 in the same cycle the state is entered. A pending half-bit is discarded.
- A new start can be detected the cycle after IDLE is entered.
- Simultaneous events:
  - RxBusy fall and BITCLK toggle in the same cycle: IDLE wins.
  - wUCSWRST and start detect in the same cycle: stay in IDLE.
- reset_n low mid-frame: all outputs return to reset values on the next MCLK edge.

## Configuration
- EUSCI_RX_DEGLITCH_EN defined: a 3-stage majority-free filter follows the synchronizer. RxSync changes only after the synchronized Rx has held a new value for 3 consecutive MCLK. Pulses of 2 MCLK or shorter are rejected.
- Not defined: RxSync is the plain 2-FF output.

## Structure
- Shared eUSCI package holds:
  - state encoding constants (IDLE/START/RUN)
  - the UCBRW zero-clamp function
  - the sub-tick count constants (16, mid = 8)
- One sub-module is natural: eusci_rx_sync (synchronizer plus optional deglitch filter, outputs RxSync). The top holds the FSM and the dividers.

## Test plan
- Low-frequency timing: UCOS16=0, UCBRW=6, UCBRS=0, BRCLKEN=1; Rx falls; hold RxBusy=1 after the first BITCLK edge → first BITCLK rise 4 MCLK after START entry, period 6 MCLK, Running=1.
- Oversampling with modulation: UCOS16=1, UCBRW=2, UCBRF=3, UCBRS=8'h01 → bit 0 = 36 MCLK, bits 1-7 = 35 MCLK; rise at sub-tick 8 of each bit.
- False start: Rx low 1 bit; RxBusy held 0 → return to IDLE after the 2nd BITCLK rise; BITCLK=0, Running=0.
- End of frame and restart: drop RxBusy during RUN → IDLE the next cycle. Immediate second falling edge → new START, counters cleared.
- Abort conditions: wUCSWRST=1 mid-bit, and separately reset_n=0 mid-bit → BITCLK=0 and IDLE on the next edge; RxSync=1 after reset.
- BRCLKEN=0 for 5 cycles mid-bit → BITCLK rise delayed by exactly 5 MCLK. With EUSCI_RX_DEGLITCH_EN, a 2-MCLK Rx low pulse → no start detect.

Source files
------------

// File: rtl/eusci_rx_baudgen_pkg.sv
// Shared eUSCI receive definitions: FSM states, sub-tick constants, prescaler clamp.
package eusci_rx_baudgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } rx_state_t;

  localparam int unsigned SUBTICKS     = 16;
  localparam logic [3:0]  SUBTICK_MID  = 4'd8;
  localparam logic [3:0]  SUBTICK_LAST = 4'(SUBTICKS - 1);

  // A zero prescaler behaves as a divide-by-one.
  function automatic logic [16:0] brw_clamp(input logic [15:0] brw);
    return (brw == 16'd0) ? 17'd1 : {1'b0, brw};
  endfunction

endpackage

// File: rtl/eusci_rx_sync.sv
// Rx pin synchronizer; EUSCI_RX_DEGLITCH_EN adds a 3-sample hold filter after it.
module eusci_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_sync
);

  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!reset_n) sync_pipe <= 2'b11;
    else          sync_pipe <= {sync_pipe[0], rx};
  end

`ifdef EUSCI_RX_DEGLITCH_EN
  logic [1:0] hist;
  logic       filt;

  // Output follows only once the synchronized level has been stable for 3 samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync_pipe[1]};
      if (sync_pipe[1] == hist[0] && hist[0] == hist[1]) filt <= sync_pipe[1];
    end
  end

  assign rx_sync = filt;
`else
  assign rx_sync = sync_pipe[1];
`endif

endmodule

// File: rtl/eusci_rx_baudgen.sv
// eUSCI_A UART receive baud generator: start detect, mid-bit BITCLK, LF and OS16 modulation.
// Optional Rx deglitch filter enabled by defining EUSCI_RX_DEGLITCH_EN.
module eusci_rx_baudgen
  import eusci_rx_baudgen_pkg::*;
(
  input  logic        MCLK,
  input  logic        reset_n,
  input  logic        BRCLKEN,
  input  logic        wUCSWRST,
  input  logic        wUCOS16,
  input  logic [15:0] wUCBRW,
  input  logic [3:0]  wUCBRF,
  input  logic [7:0]  wUCBRS,
  input  logic        Rx,
  input  logic        RxBusy,
  output logic        BITCLK,
  output logic        RxSync,
  output logic        Running
);

  rx_state_t   state, state_nxt;
  logic        rx_prev;
  logic [15:0] cnt;
  logic [3:0]  sub;
  logic [2:0]  bidx;

  logic [16:0] brw, len;
  logic        extra, half, cnt_last, bit_end, start_det, bit_rise;

  eusci_rx_sync u_sync (
    .clk     (MCLK),
    .reset_n (reset_n),
    .rx      (Rx),
    .rx_sync (RxSync)
  );

  // Length of the current prescale interval and whether we are in the second half of the bit.
  always_comb begin
    brw   = brw_clamp(wUCBRW);
    extra = wUCBRS[bidx];
    len   = brw;
    half  = 1'b0;
    if (wUCOS16) begin
      len  = brw + {16'd0, (sub < wUCBRF)} + {16'd0, (sub == SUBTICK_LAST) & extra};
      half = (sub >= SUBTICK_MID);
    end else begin
      len  = brw + {16'd0, extra};
      half = ({1'b0, cnt} >= (len >> 1));
    end
    cnt_last = (({1'b0, cnt} + 17'd1) >= len);
    bit_end  = cnt_last && (!wUCOS16 || sub == SUBTICK_LAST);
  end

  assign start_det = (state == ST_IDLE) && rx_prev && !RxSync;
  assign bit_rise  = BRCLKEN && half && !BITCLK;
  assign Running   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_det) state_nxt = ST_START;
      // The rise in bit 1 is the second BITCLK rise of the frame.
      ST_START: if (bit_rise && bidx == 3'd1) state_nxt = RxBusy ? ST_RUN : ST_IDLE;
      ST_RUN:   if (!RxBusy) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (wUCSWRST) state_nxt = ST_IDLE;
  end

  always_ff @(posedge MCLK) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rx_prev <= 1'b1;
      cnt     <= 16'd0;
      sub     <= 4'd0;
      bidx    <= 3'd0;
      BITCLK  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_prev <= RxSync;
      // Counters and BITCLK are cleared while idle, on entry to START and on any abort.
      if (state == ST_IDLE || state_nxt == ST_IDLE) begin
        cnt    <= 16'd0;
        sub    <= 4'd0;
        bidx   <= 3'd0;
        BITCLK <= 1'b0;
      end else if (BRCLKEN) begin
        BITCLK <= half;
        cnt    <= cnt_last ? 16'd0 : cnt + 16'd1;
        if (wUCOS16 && cnt_last) sub <= sub + 4'd1;
        if (bit_end) bidx <= bidx + 3'd1;
      end
    end
  end

endmodule
